// File: rtl/ernic_cmac_tx_pkt_fifo.sv
// Store-and-forward packet FIFO from the ERNIC TX stream (no tready) to the CMAC TX AXIS port.
// Build macro ERNIC_TXF_KEEP_CHK_EN additionally drops packets that carry a malformed tkeep.
module ernic_cmac_tx_pkt_fifo #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = 64,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = 7
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,
  output logic [AW:0]       pkt_cnt,
  output logic [AW:0]       level,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned WordW    = DATA_W + KEEP_W + 1;
  localparam logic [AW:0] DepthPtr = (AW+1)'(DEPTH);
  localparam logic [AW:0] PtrOne   = (AW+1)'(1);

  typedef enum logic [1:0] {StIdle, StWr, StDrop} wr_state_e;

  wr_state_e   state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fetch_ptr_q, fetch_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        commit_q, commit_d;
  logic        ram_vld_q, ram_vld_d;
  logic        out_vld_q, out_vld_d;
  logic [WordW-1:0] out_q;
  logic [WordW-1:0] rdata_q;
  logic [WordW-1:0] mem_q [DEPTH];

  logic wr_en, drop_pkt, full, keep_bad;
  logic avail, rd_en, out_load, hs;

  // rd_ptr only advances on the output handshake, so prefetched beats still count as occupied.
  assign full = (wr_ptr_q - rd_ptr_q) == DepthPtr;

`ifdef ERNIC_TXF_KEEP_CHK_EN
  assign keep_bad = s_axis_tlast ? (s_axis_tkeep == '0) : (s_axis_tkeep != '1);
`else
  assign keep_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    commit_d     = 1'b0;
    drop_pkt     = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        StIdle, StWr: begin
          if (full || keep_bad) begin
            wr_ptr_d = commit_ptr_q;
            drop_pkt = 1'b1;
            state_d  = s_axis_tlast ? StIdle : StDrop;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            if (s_axis_tlast) begin
              commit_ptr_d = wr_ptr_q + PtrOne;
              commit_d     = 1'b1;
              state_d      = StIdle;
            end else begin
              state_d = StWr;
            end
          end
        end
        StDrop: begin
          if (s_axis_tlast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign hs       = out_vld_q && m_axis_tready;
  assign avail    = fetch_ptr_q != commit_ptr_q;
  assign out_load = ram_vld_q && (!out_vld_q || hs);
  assign rd_en    = avail && (!ram_vld_q || out_load);

  always_comb begin
    fetch_ptr_d = rd_en ? fetch_ptr_q + PtrOne : fetch_ptr_q;
    rd_ptr_d    = hs ? rd_ptr_q + PtrOne : rd_ptr_q;
    ram_vld_d   = rd_en || (ram_vld_q && !out_load);
    out_vld_d   = out_load || (out_vld_q && !hs);
    drop_cnt_d  = (drop_pkt && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    // Commit is seen one cycle late so pkt_cnt never counts a packet the reader cannot yet see.
    unique case ({commit_q, hs && out_q[WordW-1]})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PtrOne;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PtrOne;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      commit_q     <= 1'b0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      commit_q     <= commit_d;
      ram_vld_q    <= ram_vld_d;
      out_vld_q    <= out_vld_d;
      if (out_load) out_q <= rdata_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge aclk) begin
    if (rd_en) rdata_q <= mem_q[fetch_ptr_q[AW-1:0]];
  end

  assign m_axis_tdata  = out_q[DATA_W-1:0];
  assign m_axis_tkeep  = out_q[DATA_W +: KEEP_W];
  assign m_axis_tlast  = out_q[WordW-1];
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tuser  = 1'b0;
  assign pkt_cnt       = pkt_cnt_q;
  assign level         = wr_ptr_q - rd_ptr_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
